// File: rtl/ni_initiator_req_packetizer_pkg.sv
// Shared NoC parameters for the NI initiator request path: default widths,
// header field offsets and the packetizer state encoding.
package ni_initiator_req_packetizer_pkg;

    localparam int unsigned NOC_FLIT_W = 80;
    localparam int unsigned NOC_PATH_W = 7;
    localparam int unsigned NOC_TGT_W  = 4;
    localparam int unsigned NOC_DATA_W = 64;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 8;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned SRC_W      = 4;

    // Header field offsets
    localparam int unsigned PATH_LSB = 0;
    localparam int unsigned TGT_LSB  = 7;
    localparam int unsigned WR_BIT   = 11;
    localparam int unsigned LEN_LSB  = 12;
    localparam int unsigned ADDR_LSB = 20;
    localparam int unsigned SRC_LSB  = 52;
    localparam int unsigned TAG_LSB  = 56;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_ERROR
    } pkt_state_t;

endpackage

// File: rtl/ni_initiator_req_packetizer_header_format.sv
// Combinational packer of request header fields into a single flit.
module ni_header_format
    import ni_initiator_req_packetizer_pkg::*;
#(
    parameter int unsigned FLIT_W = NOC_FLIT_W,
    parameter int unsigned PATH_W = NOC_PATH_W,
    parameter int unsigned TGT_W  = NOC_TGT_W,
    parameter logic [SRC_W-1:0] SRC_ID = 4'h0
) (
    input  logic [PATH_W-1:0] i_path,
    input  logic [TGT_W-1:0]  i_target,
    input  logic              i_write,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [TAG_W-1:0]  i_tag,
    output logic [FLIT_W-1:0] o_flit
);

    // Place each field at its header offset; unused upper bits stay zero
    always_comb begin
        o_flit                      = '0;
        o_flit[PATH_LSB +: PATH_W]  = i_path;
        o_flit[TGT_LSB  +: TGT_W]   = i_target;
        o_flit[WR_BIT]              = i_write;
        o_flit[LEN_LSB  +: LEN_W]   = i_len;
        o_flit[ADDR_LSB +: ADDR_W]  = i_addr;
        o_flit[SRC_LSB  +: SRC_W]   = SRC_ID;
        o_flit[TAG_LSB  +: TAG_W]   = i_tag;
    end

endmodule

// File: rtl/ni_initiator_req_packetizer.sv
// NI initiator request packetizer: route lookup, header flit, write payload
// flits; undecodable transactions sink their write data and raise an error.
module ni_initiator_req_packetizer
    import ni_initiator_req_packetizer_pkg::*;
#(
    parameter int unsigned FLIT_W = NOC_FLIT_W,
    parameter int unsigned PATH_W = NOC_PATH_W,
    parameter int unsigned TGT_W  = NOC_TGT_W,
    parameter logic [SRC_W-1:0] SRC_ID = 4'h0,
    parameter int unsigned DATA_W = NOC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_write,
    input  logic [7:0]        req_len,
    input  logic [3:0]        req_tag,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_last,
    output logic [31:0]       lut_address,
    input  logic [PATH_W-1:0] lut_path,
    input  logic [TGT_W-1:0]  transaction_target,
    input  logic              failed_decoding,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [FLIT_W-1:0] flit_data,
    output logic              flit_last,
    output logic              err_valid,
    input  logic              err_ready,
    output logic [3:0]        err_tag,
    output logic              len_mismatch
);

    pkt_state_t r_state, w_next;

    logic [31:0]       r_addr;
    logic              r_write;
    logic [7:0]        r_len;
    logic [3:0]        r_tag;
    logic [PATH_W-1:0] r_path;
    logic [TGT_W-1:0]  r_tgt;
    logic [7:0]        r_beat_cnt;
    logic              r_len_mismatch;

    logic [FLIT_W-1:0] w_header;
    logic [FLIT_W-1:0] w_payload;
    logic              w_beat;
    logic              w_cnt_zero;

    ni_header_format #(
        .FLIT_W (FLIT_W),
        .PATH_W (PATH_W),
        .TGT_W  (TGT_W),
        .SRC_ID (SRC_ID)
    ) u_header_format (
        .i_path   (r_path),
        .i_target (r_tgt),
        .i_write  (r_write),
        .i_len    (r_len),
        .i_addr   (r_addr),
        .i_tag    (r_tag),
        .o_flit   (w_header)
    );

    assign lut_address  = r_addr;
    assign len_mismatch = r_len_mismatch;
    assign w_cnt_zero   = (r_beat_cnt == 8'd0);
    assign w_beat       = wdata_valid & wdata_ready;

    // Zero-extend a write beat to flit width
    always_comb begin
        w_payload               = '0;
        w_payload[DATA_W-1:0]   = wdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        flit_valid  = 1'b0;
        flit_data   = '0;
        flit_last   = 1'b0;
        err_valid   = 1'b0;
        err_tag     = '0;
        case (r_state)
            ST_IDLE: begin
                // Held low while reset is asserted so no request is acknowledged
                req_ready = rst_n;
                if (req_valid) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (failed_decoding) begin
                    w_next = r_write ? ST_DRAIN : ST_ERROR;
                end else begin
                    w_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                flit_valid = 1'b1;
                flit_data  = w_header;
                flit_last  = ~r_write;
                if (flit_ready) begin
                    w_next = r_write ? ST_PAYLOAD : ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                wdata_ready = flit_ready;
                flit_valid  = wdata_valid;
                flit_data   = w_payload;
                flit_last   = w_cnt_zero;
                if (wdata_valid && flit_ready && w_cnt_zero) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                wdata_ready = 1'b1;
                if (wdata_valid && w_cnt_zero) begin
                    w_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                err_valid = 1'b1;
                err_tag   = r_tag;
                if (err_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, route registration, beat counting and mismatch flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_write        <= 1'b0;
            r_len          <= '0;
            r_tag          <= '0;
            r_path         <= '0;
            r_tgt          <= '0;
            r_beat_cnt     <= '0;
            r_len_mismatch <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_len   <= req_len;
                r_tag   <= req_tag;
            end
            if (r_state == ST_LOOKUP) begin
                r_path     <= lut_path;
                r_tgt      <= transaction_target;
                // Loaded here so PAYLOAD and DRAIN share one counter preload
                r_beat_cnt <= r_len;
            end
            if (w_beat) begin
                if (!w_cnt_zero) begin
                    r_beat_cnt <= r_beat_cnt - 8'd1;
                end
                if (wdata_last != w_cnt_zero) begin
                    r_len_mismatch <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ni_initiator_req_packetizer.sv
// Scoreboard bench for ni_initiator_req_packetizer: stimulus pushes expected
// flits/error tags, a negedge monitor pops and compares on each handshake.
module tb_ni_initiator_req_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [7:0]  req_len;
    logic [3:0]  req_tag;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [63:0] wdata;
    logic        wdata_last;
    logic [31:0] lut_address;
    logic [6:0]  lut_path;
    logic [3:0]  transaction_target;
    logic        failed_decoding;
    logic        flit_valid;
    logic        flit_ready;
    logic [79:0] flit_data;
    logic        flit_last;
    logic        err_valid;
    logic        err_ready;
    logic [3:0]  err_tag;
    logic        len_mismatch;

    typedef struct packed {
        logic [79:0] data;
        logic        last;
    } flit_t;

    flit_t       exp_q[$];
    logic [3:0]  err_q[$];
    flit_t       mon_e;
    logic [3:0]  mon_t;
    int          errors = 0;
    int          checks = 0;
    logic        rand_ready = 1'b0;
    logic        quiet = 1'b0;
    int          quiet_hits = 0;
    logic        prev_stall = 1'b0;
    logic [79:0] prev_data = '0;

    always #5 clk = ~clk;

    ni_initiator_req_packetizer #(
        .FLIT_W (80),
        .PATH_W (7),
        .TGT_W  (4),
        .SRC_ID (4'h0),
        .DATA_W (64)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_addr           (req_addr),
        .req_write          (req_write),
        .req_len            (req_len),
        .req_tag            (req_tag),
        .wdata_valid        (wdata_valid),
        .wdata_ready        (wdata_ready),
        .wdata              (wdata),
        .wdata_last         (wdata_last),
        .lut_address        (lut_address),
        .lut_path           (lut_path),
        .transaction_target (transaction_target),
        .failed_decoding    (failed_decoding),
        .flit_valid         (flit_valid),
        .flit_ready         (flit_ready),
        .flit_data          (flit_data),
        .flit_last          (flit_last),
        .err_valid          (err_valid),
        .err_ready          (err_ready),
        .err_tag            (err_tag),
        .len_mismatch       (len_mismatch)
    );

    // Routing LUT stand-in
    always_comb begin
        lut_path           = '0;
        transaction_target = '0;
        failed_decoding    = 1'b0;
        if (lut_address[31:20] == 12'h104) begin
            lut_path           = 7'b0000001;
            transaction_target = 4'h5;
        end else if (lut_address[31:24] == 8'h1a) begin
            lut_path           = 7'b0000111;
            transaction_target = 4'hc;
        end else begin
            failed_decoding = 1'b1;
        end
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    function automatic logic [79:0] hdr(input logic [31:0] a, input logic w, input logic [7:0] l,
                                        input logic [3:0] t, input logic [6:0] p, input logic [3:0] g);
        return {20'h0, t, 4'h0, a, l, w, g, p};
    endfunction

    task automatic push_read(input logic [31:0] a, input logic [3:0] t, input logic [6:0] p, input logic [3:0] g);
        exp_q.push_back('{data: hdr(a, 1'b0, 8'd0, t, p, g), last: 1'b1});
    endtask

    task automatic push_write(input logic [31:0] a, input logic [7:0] l, input logic [3:0] t,
                              input logic [6:0] p, input logic [3:0] g, input logic [63:0] base);
        exp_q.push_back('{data: hdr(a, 1'b1, l, t, p, g), last: 1'b0});
        for (int i = 0; i <= int'(l); i++) begin
            exp_q.push_back('{data: {16'h0, base + 64'(i)}, last: (i == int'(l))});
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [7:0] l, input logic [3:0] t);
        int n;
        req_addr  = a;
        req_write = w;
        req_len   = l;
        req_tag   = t;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) timeout_fail("req_accept");
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic beats(input int cnt, input logic [63:0] base, input int last_idx);
        int n;
        for (int i = 0; i < cnt; i++) begin
            wdata_valid = 1'b1;
            wdata       = base + 64'(i);
            wdata_last  = (i == last_idx);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!wdata_ready && n < 200);
            if (!wdata_ready) timeout_fail("wdata_accept");
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
        wdata_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && err_q.size() == 0 && req_ready) && n < 500);
        if (!(exp_q.size() == 0 && err_q.size() == 0 && req_ready)) timeout_fail(name);
        @(posedge clk);
        #1;
    endtask

    // Downstream flit ready driver: constant or random
    initial begin
        flit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 flit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare each accepted flit / error response against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (flit_valid && flit_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("flit_unexpected");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("flit_data", flit_data, mon_e.data);
                    check("flit_last", 80'(flit_last), 80'(mon_e.last));
                end
            end
            if (prev_stall) begin
                check("flit_hold_valid", 80'(flit_valid), 80'd1);
                check("flit_hold_data", flit_data, prev_data);
            end
            prev_stall = flit_valid && !flit_ready;
            prev_data  = flit_data;
            if (err_valid && err_ready) begin
                if (err_q.size() == 0) begin
                    timeout_fail("err_unexpected");
                end else begin
                    mon_t = err_q.pop_front();
                    check("err_tag", 80'(err_tag), 80'(mon_t));
                end
            end
            if (quiet && flit_valid) quiet_hits++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_write   = 1'b0;
        req_len     = '0;
        req_tag     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        wdata_last  = 1'b0;
        err_ready   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 80'(req_ready), 80'd0);
        check("rst_wdata_ready", 80'(wdata_ready), 80'd0);
        check("rst_flit_valid", 80'(flit_valid), 80'd0);
        check("rst_flit_last", 80'(flit_last), 80'd0);
        check("rst_err_valid", 80'(err_valid), 80'd0);
        check("rst_len_mismatch", 80'(len_mismatch), 80'd0);
        check("rst_flit_data", flit_data, 80'd0);
        check("rst_err_tag", 80'(err_tag), 80'd0);
        check("rst_lut_address", 80'(lut_address), 80'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 80'(req_ready), 80'd1);
        @(posedge clk);
        #1;

        // Read, routed
        push_read(32'h10400010, 4'h3, 7'b0000001, 4'h5);
        issue(32'h10400010, 1'b0, 8'd0, 4'h3);
        wait_idle("read1_done");

        // Write len=2, data A,B,C
        push_write(32'h1a000000, 8'd2, 4'h5, 7'b0000111, 4'hc, 64'hA);
        issue(32'h1a000000, 1'b1, 8'd2, 4'h5);
        beats(3, 64'hA, 2);
        wait_idle("write3_done");
        check("mismatch_clear", 80'(len_mismatch), 80'd0);

        // Undecodable write: data sunk, error held until accepted
        quiet      = 1'b1;
        quiet_hits = 0;
        err_q.push_back(4'h9);
        issue(32'h20000000, 1'b1, 8'd1, 4'h9);
        beats(2, 64'h5500, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_valid && n < 50);
        if (!err_valid) timeout_fail("err_raise");
        for (int i = 0; i < 3; i++) begin
            check("err_hold_valid", 80'(err_valid), 80'd1);
            check("err_hold_tag", 80'(err_tag), 80'h9);
            @(negedge clk);
        end
        @(posedge clk);
        #1 err_ready = 1'b1;
        wait_idle("err_write_done");
        check("drain_no_flit", 80'(quiet_hits), 80'd0);

        // Undecodable read goes straight to error
        err_q.push_back(4'ha);
        issue(32'h30000000, 1'b0, 8'd0, 4'ha);
        wait_idle("err_read_done");
        check("err_read_no_flit", 80'(quiet_hits), 80'd0);
        err_ready = 1'b0;
        quiet     = 1'b0;

        // len=7 write under random backpressure
        rand_ready = 1'b1;
        push_write(32'h1a000100, 8'd7, 4'h6, 7'b0000111, 4'hc, 64'h1000_0000_0000_0000);
        issue(32'h1a000100, 1'b1, 8'd7, 4'h6);
        beats(8, 64'h1000_0000_0000_0000, 7);
        wait_idle("bp_write_done");
        rand_ready = 1'b0;
        check("mismatch_still_clear", 80'(len_mismatch), 80'd0);

        // Early wdata_last on beat 1 of len=3: counter still rules
        push_write(32'h1a000200, 8'd3, 4'h7, 7'b0000111, 4'hc, 64'h7700);
        issue(32'h1a000200, 1'b1, 8'd3, 4'h7);
        beats(4, 64'h7700, 1);
        wait_idle("mismatch_write_done");
        check("mismatch_set", 80'(len_mismatch), 80'd1);

        // len=0 write: single beat; mismatch flag sticky
        push_write(32'h1a000300, 8'd0, 4'h8, 7'b0000111, 4'hc, 64'h8800);
        issue(32'h1a000300, 1'b1, 8'd0, 4'h8);
        beats(1, 64'h8800, 0);
        wait_idle("len0_done");
        check("mismatch_sticky", 80'(len_mismatch), 80'd1);

        // len=255 write: 256 beats
        push_write(32'h1a000400, 8'd255, 4'hb, 7'b0000111, 4'hc, 64'hB0000);
        issue(32'h1a000400, 1'b1, 8'd255, 4'hb);
        beats(256, 64'hB0000, 255);
        wait_idle("len255_done");

        // Reset mid-payload abandons the packet
        push_write(32'h1a000500, 8'd3, 4'h2, 7'b0000111, 4'hc, 64'h2200);
        issue(32'h1a000500, 1'b1, 8'd3, 4'h2);
        beats(2, 64'h2200, 3);
        rst_n       = 1'b0;
        wdata_valid = 1'b1;
        wdata       = 64'h2202;
        @(posedge clk);
        #1;
        wdata_valid = 1'b0;
        exp_q.delete();
        check("midrst_flit_valid", 80'(flit_valid), 80'd0);
        check("midrst_wdata_ready", 80'(wdata_ready), 80'd0);
        check("midrst_err_valid", 80'(err_valid), 80'd0);
        check("midrst_len_mismatch", 80'(len_mismatch), 80'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", 80'(req_ready), 80'd1);
        check("midrst_no_flit", 80'(flit_valid), 80'd0);
        @(posedge clk);
        #1;

        // Read after reset completes normally
        push_read(32'h10400020, 4'hf, 7'b0000001, 4'h5);
        issue(32'h10400020, 1'b0, 8'd0, 4'hf);
        wait_idle("read2_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ni_initiator_req_packetizer.md
Name: ni_initiator_req_packetizer

Overview:
Request-side packetizer of the NI initiator. It accepts one master transaction (address, command, burst length, tag, write data), drives the address into the combinational routing LUT, and registers the resulting path, target and decode status. It then emits a header flit followed by write payload flits to the NI output buffer. Transactions that fail decoding are never injected; write data for them is sunk and a local error response is raised.

Parameters:
FLIT_W, 80, flit width in bits
PATH_W, 7, source-route path width
TGT_W, 4, target ID width
SRC_ID, 4'h0, this initiator's ID, placed in the header
DATA_W, 64, write data width (must be <= FLIT_W)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  32  transaction address
req_write  in  1  1=write, 0=read
req_len  in  8  burst length minus 1
req_tag  in  4  transaction tag
wdata_valid  in  1  write beat valid
wdata_ready  out  1  write beat accepted
wdata  in  DATA_W  write beat data
wdata_last  in  1  master's last-beat marker
lut_address  out  32  address to the routing LUT
lut_path  in  PATH_W  route from the LUT
transaction_target  in  TGT_W  target ID from the LUT
failed_decoding  in  1  address matched no range
flit_valid  out  1  flit valid
flit_ready  in  1  downstream accepts flit
flit_data  out  FLIT_W  flit contents
flit_last  out  1  final flit of the packet
err_valid  out  1  decode-error response valid
err_ready  in  1  error response accepted
err_tag  out  4  tag of the failed transaction
len_mismatch  out  1  sticky flag: wdata_last disagreed with the beat count

Behaviour:
- Reset (sync, rst_n=0 at a clk edge): state=IDLE; req_ready, wdata_ready, flit_valid, flit_last, err_valid, len_mismatch = 0; flit_data, err_tag, lut_address = 0.
- An assertion of reset mid-packet abandons the packet with no trailing flit. The downstream block owns the recovery.
- FSM states: IDLE, LOOKUP, HEADER, PAYLOAD, DRAIN, ERROR.
- IDLE:
  - req_ready=1.
  - On handshake at edge T, register addr, write, len and tag, then go to LOOKUP.
- LOOKUP (cycle T+1):
  - lut_address is driven from the registered address (it is a registered output, stable for the whole transaction).
  - At the end of the cycle, register lut_path, transaction_target and failed_decoding.
  - If failed_decoding=1: go to DRAIN for a write, or ERROR for a read. Otherwise go to HEADER.
- HEADER (header flit_valid from T+2):
  - Header layout:
    - [6:0] path
    - [10:7] target
    - [11] write
    - [19:12] len
    - [51:20] addr
    - [55:52] SRC_ID
    - [59:56] tag
    - [79:60] 0
  - flit_last = ~write.
  - flit_valid and flit_data are held stable until flit_ready.
  - On handshake: a read goes to IDLE; a write loads beat_cnt=len and goes to PAYLOAD.
- PAYLOAD:
  - wdata_ready = flit_ready (combinational pass-through): flit_valid = wdata_valid, flit_data = {zero-extended, wdata}.
  - flit_last = (beat_cnt==0).
  - On each beat handshake, decrement beat_cnt. On the beat where beat_cnt==0, go to IDLE.
- DRAIN:
  - wdata_ready=1, flit_valid=0.
  - Consume len+1 beats using the same counter, then go to ERROR.
- ERROR:
  - err_valid=1, err_tag=tag.
  - On err_ready, go to IDLE.
- Beat count:
  - beat_cnt governs the packet length; wdata_last is never used to terminate.
  - If wdata_last differs from (beat_cnt==0) on any accepted beat, set len_mismatch (cleared only by reset).
- req_ready=0 in every state except IDLE. Throughput is one transaction per (3 + payload beats) cycles minimum.
- len=0 write means exactly one payload beat. len=255 means 256 beats; the counter is 8 bits and has no wrap.
- Backpressure of any length in HEADER, PAYLOAD or ERROR must not lose or duplicate data.

Decomposition:
- Shared package/include (noc_parameters): FLIT_W, header field offsets/widths (PATH_LSB, TGT_LSB, WR_BIT, LEN_LSB, ADDR_LSB, SRC_LSB, TAG_LSB), the state encoding, and TGT_W/PATH_W.
- One natural sub-module: ni_header_format, a purely combinational packer of the header fields into a flit.
- The routing LUT is instantiated by the parent NI, not inside this block.

Test Plan:
- Read at 32'h10400010, tag 3, flit_ready=1:
  - header at T+2: path=7'b0000001, target=4'h5, write=0, flit_last=1.
  - req_ready returns high at T+3.
- Write at 32'h1a000000, len=2, data A,B,C:
  - header with path=7'b0000111, target=4'hc.
  - then 3 payload flits with flit_last on C only.
- Write to 32'h20000000 (decode fails), len=1:
  - two wdata beats consumed, no flit_valid.
  - err_valid with err_tag matching the request; held until err_ready.
- Random flit_ready toggling on a len=7 write:
  - all 8 beats delivered in order, no duplicates.
  - flit_data stable while flit_valid & ~flit_ready.
- wdata_last asserted on beat 1 of a len=3 write:
  - 4 beats still sent, last on beat 3.
  - len_mismatch=1 and stays set.
- rst_n=0 during PAYLOAD:
  - next cycle all valids=0, state IDLE, len_mismatch=0.
  - a following read completes normally.
